// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 datapath mux between four requesters; grant/select/busy registered.
// Latency: request sampled at edge t appears as grant after edge t (1 cycle); owner hand-off has no idle bubble.
// Backpressure: requests are level-held; a requester waits until the owner releases (or is preempted when
//               ARB_HOLD_LIMIT_EN is defined and the owner has held for MAX_HOLD cycles while others wait).
//
// Ports:
//   i_clk       system clock, rising-edge
//   i_reset     synchronous active-high reset
//   i_req[3:0]  level request vector
//   o_grant     one-hot grant, zero when idle
//   o_select    binary index of the granted requester (mux select)
//   o_busy      grant active
//   o_hold_cnt  cycles the current owner has held the grant minus 1, saturating; 0 when idle
//
// Optional feature macro: ARB_HOLD_LIMIT_EN (hold-limit preemption using MAX_HOLD).

module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [3:0]        i_req,
    output logic [3:0]        o_grant,
    output logic [1:0]        o_select,
    output logic              o_busy,
    output logic [HOLD_W-1:0] o_hold_cnt
);

    // Reject parameter sets where the hold counter cannot represent the limit.
    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << HOLD_W) <= MAX_HOLD) begin : g_bad_param
        $error("mux_rr_arbiter: illegal MAX_HOLD/HOLD_W combination");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [1:0]        r_last;
    logic [3:0]        r_grant;
    logic [1:0]        r_select;
    logic              r_busy;
    logic [HOLD_W-1:0] r_hold_cnt;

    // Returns {found, index}: first set bit of req searching upward (mod 4)
    // from last+1. Iterating from the far end down lets the nearest hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] w_pick_idle;
    logic [2:0] w_pick_next;
    logic       w_owner_req;
    logic       w_preempt;

    // From IDLE the search starts after the remembered last owner; from GRANT
    // the current owner becomes the last owner, so it gets lowest priority.
    assign w_pick_idle = rr_pick(i_req, r_last);
    assign w_pick_next = rr_pick(i_req, r_select);
    assign w_owner_req = i_req[r_select];

`ifdef ARB_HOLD_LIMIT_EN
    logic w_others;
    assign w_others  = |(i_req & ~r_grant);
    assign w_preempt = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) && w_others;
`else
    assign w_preempt = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_last     <= 2'd3;
            r_grant    <= 4'b0000;
            r_select   <= 2'b00;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_idle[2]) begin
                        r_state    <= S_GRANT;
                        r_grant    <= 4'b0001 << w_pick_idle[1:0];
                        r_select   <= w_pick_idle[1:0];
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (!w_owner_req || w_preempt) begin
                        r_last <= r_select;
                        if (w_pick_next[2]) begin
                            // Direct hand-off on the same edge, no idle bubble.
                            r_grant    <= 4'b0001 << w_pick_next[1:0];
                            r_select   <= w_pick_next[1:0];
                            r_hold_cnt <= '0;
                        end else begin
                            // select keeps its last value while idle.
                            r_state    <= S_IDLE;
                            r_grant    <= 4'b0000;
                            r_busy     <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant    = r_grant;
    assign o_select   = r_select;
    assign o_busy     = r_busy;
    assign o_hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a reference model pushes the expected outputs per edge,
// a monitor pops and compares #1 after each rising edge.
// Stimulus: directed test-plan sequences followed by randomized level requests and sporadic resets.

module tb_mux_rr_arbiter;

    localparam int HOLD_W  = 4;
    localparam int HOLD_SAT = (1 << HOLD_W) - 1;
`ifdef ARB_HOLD_LIMIT_EN
    localparam int MAX_HOLD = 8;
`endif

    logic              clk;
    logic              reset;
    logic [3:0]        req;
    logic [3:0]        grant;
    logic [1:0]        select;
    logic              busy;
    logic [HOLD_W-1:0] hold_cnt;

    mux_rr_arbiter #(
        .MAX_HOLD (8),
        .HOLD_W   (HOLD_W)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req      (req),
        .o_grant    (grant),
        .o_select   (select),
        .o_busy     (busy),
        .o_hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic [3:0] h;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: owner as an integer (-1 = nobody), plain counters.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_hold  = 0;
    int m_win;
    bit m_rotate;
    exp_t m_e;

    function automatic int next_winner(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_last  = 3;
            m_sel   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            m_win = next_winner(req, m_last);
            if (m_win >= 0) begin
                m_owner = m_win;
                m_sel   = m_win;
                m_hold  = 0;
            end
        end else begin
            m_rotate = (req[m_owner] == 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
            if (req[m_owner] && m_hold == MAX_HOLD - 1 && (req & ~(4'b0001 << m_owner)) != 4'b0000)
                m_rotate = 1'b1;
`endif
            if (m_rotate) begin
                m_last = m_owner;
                m_win  = next_winner(req, m_last);
                m_hold = 0;
                if (m_win >= 0) begin
                    m_owner = m_win;
                    m_sel   = m_win;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold = (m_hold < HOLD_SAT) ? m_hold + 1 : HOLD_SAT;
            end
        end
        m_e.g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        m_e.s = 2'(m_sel);
        m_e.b = (m_owner >= 0);
        m_e.h = 4'(m_hold);
        q.push_back(m_e);
    end

    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
        end else begin
            mon_e = q.pop_front();
            n_tests++;
            if (grant !== mon_e.g) begin
                n_fail++;
                $display("FAIL grant @%0t: got %b expected %b (req=%b)", $time, grant, mon_e.g, req);
            end
            n_tests++;
            if (select !== mon_e.s) begin
                n_fail++;
                $display("FAIL select @%0t: got %b expected %b", $time, select, mon_e.s);
            end
            n_tests++;
            if (busy !== mon_e.b) begin
                n_fail++;
                $display("FAIL busy @%0t: got %b expected %b", $time, busy, mon_e.b);
            end
            n_tests++;
            if (hold_cnt !== mon_e.h) begin
                n_fail++;
                $display("FAIL hold_cnt @%0t: got %0d expected %0d", $time, hold_cnt, mon_e.h);
            end
            n_tests++;
            if ($countones(grant) > 1) begin
                n_fail++;
                $display("FAIL grant_onehot @%0t: got %b expected at most one bit", $time, grant);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        cycles(2);
        reset = 1'b0;

        // Idle after reset.
        cycles(3);

        // Requester 1 wins first, hand-off to 3 with no bubble.
        req = 4'b1010;
        cycles(2);
        req = 4'b1000;
        cycles(2);
        req = 4'b0000;
        cycles(2);

        // All requesting; each owner drops its bit right after being granted.
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = 4'b1111 & ~grant;
        end
        req = 4'b0000;
        cycles(2);

        // Reset mid-grant, then requester 0 wins from 4'b0101.
        req = 4'b0100;
        cycles(3);
        reset = 1'b1;
        req   = 4'b0101;
        cycles(1);
        reset = 1'b0;
        cycles(3);
        req = 4'b0000;
        cycles(2);

        // Single requester held long enough to saturate hold_cnt.
        req = 4'b0100;
        cycles(20);
        req = 4'b0000;
        cycles(2);

        // Two requesters held together for a long stretch.
        req = 4'b0011;
        cycles(20);
        req = 4'b0000;
        cycles(2);

        // Randomized level requests with sporadic resets.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        req   = 4'b0000;
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 datapath mux between four requesters.
- Drives the mux `select[1:0]` from the current grant and returns a one-hot grant to each requester.
- Sits between requesting units (e.g. register-file write sources, ALU operand sources) and the shared mux.
- Fully synchronous, single clock domain.

Parameters:
- MAX_HOLD, 8: max consecutive cycles one requester may own the mux while another is waiting (used only with ARB_HOLD_LIMIT_EN); legal range 1..15.
- HOLD_W, 4: width of the internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i]=1 means requester i wants the mux; level-held until done.
- grant  output  4  one-hot grant, or all-zero when idle; registered.
- select  output  2  mux select = binary index of the granted requester; registered; drives the mux select directly.
- busy  output  1  1 when any grant is active (grant != 0); registered.
- hold_cnt  output  HOLD_W  cycles the current owner has held the grant, minus 1; 0 when idle.

Behaviour:
- Reset: sampled on the rising clk edge while reset=1.
  - grant=4'b0000, select=2'b00, busy=0, hold_cnt=0, state=IDLE.
  - Last-owner pointer = 3, so requester 0 has top priority after reset.
  - Reset wins over every other event, including mid-grant; a granted requester loses its grant on the same edge.
- State IDLE (grant=0):
  - On an edge with req!=0, pick the winner: first set bit searching upward (mod 4) from last_owner+1.
  - Load grant=onehot(winner), select=winner, busy=1, hold_cnt=0, then go to GRANT.
  - Latency: req high before edge t gives grant visible after edge t (1 cycle).
  - req=0: stay in IDLE; outputs unchanged.
- State GRANT (owner = select):
  - req[owner]=1: keep the grant; hold_cnt increments and saturates at 2^HOLD_W-1.
  - req[owner]=0: release on this edge and set last_owner=owner.
    - If req has other bits set, grant the next winner on the same edge, with no idle bubble; hold_cnt=0.
    - Otherwise go to IDLE with grant=0 and busy=0; select keeps its last value.
  - Other requesters rising or falling while not owner: no effect until arbitration.
- Invariants:
  - grant is always one-hot or zero.
  - select == index of the grant bit whenever busy=1.
  - select never changes while busy=1 and the owner keeps req high, unless the hold limit forces a rotation.
- Round-robin fairness: with all four req held high and releases, grant order is 0,1,2,3,0,…
- Wrap-around: the search from last_owner=3 starts at 0; from last_owner=2 the order is 3,0,1.
- Simultaneous release by the owner and new req from others: handled in the same edge as above.
- A requester that drops and re-raises req in the same cycle it is granted is treated as continuous; req is only sampled at edges.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined: in GRANT, if hold_cnt == MAX_HOLD-1 and any other req bit is set, force a rotation on that edge.
  - last_owner=owner; grant passes to the next requester in round-robin order; hold_cnt=0.
  - The preempted owner, still requesting, gets lowest priority.
  - If no other requester is pending, the owner keeps the grant and hold_cnt saturates.
- Not defined: no preemption; the owner holds the grant for as long as req[owner]=1. MAX_HOLD is unused.

Test Plan:
- Reset then req=4'b0000 for 3 cycles -> grant=0000, select=00, busy=0, hold_cnt=0 throughout.
- After reset, req=4'b1010 -> 1 cycle later grant=0010, select=01; drop req[1] -> next edge grant=1000, select=11 with no idle cycle.
- req=4'b1111 held, each owner drops then re-raises its bit 1 cycle after grant -> grant sequence 0001,0010,0100,1000,0001; select 00,01,10,11,00.
- Owner 2 granted, reset=1 for one edge -> grant=0000, busy=0, select=00; next request from req=4'b0101 grants requester 0 first.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=3: req=4'b0011 held -> grant 0001 for 3 cycles, then 0010 for 3 cycles, then 0001; without the macro, grant stays 0001 indefinitely.
- Single requester req=4'b0100 held 20 cycles -> grant=0100, select=10 steady; hold_cnt saturates at 15 (HOLD_W=4); no preemption with or without the macro.
